// File: rtl/fir.sv
// 11-tap symmetric band-pass FIR using a single multiplier that is shared across taps.
// Each accepted sample strobe starts 11 MAC cycles and is followed by one rounding/output cycle.
module fir #(
    parameter int SIZE = 16,
    parameter int TAPS = 11,
    parameter int CW   = 16
) (
    input  logic            ck,
    input  logic            rst,
    input  logic [SIZE-1:0] in,
    input  logic            input_ready,
    output logic [SIZE-1:0] out,
    output logic            output_ready
);

    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = SIZE + CW;
    localparam int ACC_W  = PROD_W + $clog2(TAPS) + 1;

    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) <<< (CW - 2);
    localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) <<< (SIZE - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    function automatic logic signed [CW-1:0] coef(input logic [IDX_W-1:0] k);
        case (k)
            IDX_W'(0), IDX_W'(10): coef = CW'(-2804);
            IDX_W'(1), IDX_W'(9):  coef = CW'(-6000);
            IDX_W'(2), IDX_W'(8):  coef = CW'(-3867);
            IDX_W'(4), IDX_W'(6):  coef = CW'(7209);
            IDX_W'(5):             coef = CW'(10923);
            default:               coef = '0;
        endcase
    endfunction

    state_t                   state_q, state_d;
    logic                     strobe_q, strobe_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [SIZE-1:0]   x_q [TAPS];
    logic signed [SIZE-1:0]   x_d [TAPS];
    logic [SIZE-1:0]          out_q, out_d;
    logic                     output_ready_q, output_ready_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [SIZE-1:0]   sat;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
        state_d        = state_q;
        strobe_d       = input_ready;
        idx_d          = idx_q;
        acc_d          = acc_q;
        x_d            = x_q;
        out_d          = out_q;
        output_ready_d = 1'b0;

        prod    = x_q[idx_q] * coef(idx_q);
        rounded = (acc_q + HALF) >>> (CW - 1);
        if (rounded > OUT_MAX)      sat = OUT_MAX[SIZE-1:0];
        else if (rounded < OUT_MIN) sat = OUT_MIN[SIZE-1:0];
        else                        sat = rounded[SIZE-1:0];

        case (state_q)
            IDLE: begin
                if (input_ready && !strobe_q) begin
                    for (int k = TAPS - 1; k > 0; k--) x_d[k] = x_q[k-1];
                    x_d[0]  = $signed(in);
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (idx_q == IDX_W'(TAPS - 1)) state_d = DONE;
                else                           idx_d   = idx_q + IDX_W'(1);
            end
            DONE: begin
                out_d          = sat;
                output_ready_d = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            strobe_q       <= 1'b0;
            idx_q          <= '0;
            acc_q          <= '0;
            out_q          <= '0;
            output_ready_q <= 1'b0;
            // NOTE: the delay line is reset deliberately, so an aborted run cannot leak stale history.
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else begin
            state_q        <= state_d;
            strobe_q       <= strobe_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            out_q          <= out_d;
            output_ready_q <= output_ready_d;
            x_q            <= x_d;
        end
    end

    assign out          = out_q;
    assign output_ready = output_ready_q;

endmodule

// File: tb/tb_fir.sv
// Scoreboard bench for fir: stimulus pushes expected outputs, and a monitor pops one per output_ready pulse.
`timescale 1ns/1ps
module tb_fir;

    logic        ck;
    logic        rst;
    logic [15:0] in;
    logic        input_ready;
    logic [15:0] out;
    logic        output_ready;

    fir dut (
        .ck           (ck),
        .rst          (rst),
        .in           (in),
        .input_ready  (input_ready),
        .out          (out),
        .output_ready (output_ready)
    );

    initial ck = 1'b0;
    always #500 ck = ~ck;

    typedef struct {
        int    val;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   hist[11];
    int   coefs[11] = '{-2804, -6000, -3867, 0, 7209, 10923, 7209, 0, -3867, -6000, -2804};
    int   last_exp = 0;

    task automatic check(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < 11; k++) hist[k] = 0;
    endfunction

    function automatic int model_push(input int s);
        longint acc;
        for (int k = 10; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s;
        acc = 0;
        for (int k = 0; k < 11; k++) acc += longint'(coefs[k]) * longint'(hist[k]);
        acc = (acc + 16384) >>> 15;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    function automatic void push_exp(input int v, input string tag);
        exp_t e;
        e.val = v;
        e.tag = tag;
        exp_q.push_back(e);
        last_exp = v;
    endfunction

    // One sample: strobe held `hold` cycles, then idle so that the strobe period is `period` cycles.
    task automatic send(input int s, input int hold, input int period,
                        input bit use_hand, input int hand, input string tag);
        int m;
        m = model_push(s);
        push_exp(use_hand ? hand : m, tag);
        @(negedge ck);
        in = 16'(s);
        input_ready = 1'b1;
        repeat (hold) @(negedge ck);
        input_ready = 1'b0;
        repeat (period - hold - 1) @(negedge ck);
    endtask

    always @(negedge ck) begin
        exp_t e;
        if (rst && output_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output_ready", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check(e.tag, longint'($signed(out)), longint'(e.val));
            end
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d, required 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int imp_exp[13] = '{-2804, -6000, -3867, 0, 7209, 10923, 7209, 0, -3867, -6000, -2804, 0, 0};
        int sgn[11]     = '{-1, -1, -1, 0, 1, 1, 1, 0, -1, -1, -1};
        int hold_exp;
        int lat_val;
        int wait_cnt;

        rst = 1'b0;
        in = '0;
        input_ready = 1'b0;
        model_clear();
        #5;
        check("reset_out", longint'($signed(out)), 0);
        check("reset_output_ready", longint'(output_ready), 0);
        #5 rst = 1'b1;
        repeat (3) @(negedge ck);
        check("post_reset_out", longint'($signed(out)), 0);
        check("post_reset_output_ready", longint'(output_ready), 0);
        repeat (30) @(negedge ck);

        // Reset asserted mid-computation aborts the result and clears the history.
        @(negedge ck);
        in = 16'sd32767;
        input_ready = 1'b1;
        @(negedge ck);
        input_ready = 1'b0;
        repeat (5) @(negedge ck);
        rst = 1'b0;
        #10;
        check("midreset_out", longint'($signed(out)), 0);
        check("midreset_output_ready", longint'(output_ready), 0);
        rst = 1'b1;
        model_clear();
        repeat (20) @(negedge ck);

        for (int i = 0; i < 13; i++)
            send(i == 0 ? 32767 : 0, 1, 40, 1'b1, imp_exp[i], $sformatf("impulse_%0d", i));

        // Latency/handshake: a second strobe at T+5 must be ignored and must not shift the line.
        hold_exp = last_exp;
        lat_val = model_push(5000);
        push_exp(lat_val, "latency_result");
        @(negedge ck);
        in = 16'sd5000;
        input_ready = 1'b1;
        @(negedge ck);
        for (int k = 1; k <= 13; k++) begin
            input_ready = (k == 5);
            in = (k == 5) ? 16'sd1234 : 16'sd0;
            @(negedge ck);
            check($sformatf("latency_ready_T+%0d", k), longint'(output_ready), (k == 12) ? 1 : 0);
            if (k < 12) check($sformatf("latency_hold_T+%0d", k), longint'($signed(out)), longint'(hold_exp));
        end
        repeat (25) @(negedge ck);

        send(-7000, 5, 40, 1'b0, 0, "held_strobe");

        for (int i = 0; i < 15; i++)
            send(10000, 1, 40, i >= 10, 0, $sformatf("dc_%0d", i));

        for (int i = 0; i < 11; i++)
            send(32767 * sgn[10 - i], 1, 40, i == 10, 32767, $sformatf("sat_pos_%0d", i));
        for (int i = 0; i < 11; i++)
            send(-32767 * sgn[10 - i], 1, 40, i == 10, -32768, $sformatf("sat_neg_%0d", i));

        for (int i = 0; i < 48; i++)
            send((i % 8 < 4) ? 10000 : -10000, 1, 25, 1'b0, 0, $sformatf("square_%0d", i));

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 100) begin
            @(negedge ck);
            wait_cnt++;
        end
        check("drain_queue_depth", longint'(exp_q.size()), 0);
        repeat (60) @(negedge ck);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
